mem_arbiter_rv: RTL

MEM_ARBITER_RV -- requirements
Module: mem_arbiter_rv

---
 rtl/mem_arbiter_rv_pkg.sv | 20 ++
 rtl/arb_pick_rv.sv | 26 ++
 rtl/mem_arbiter_rv.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rv_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM state
// encodings, master identifiers and an address helper.
package mem_arbiter_rv_pkg;

  typedef enum logic [1:0] {
    STATE_ARB_IDLE   = 2'd0,
    STATE_ARB_ACCESS = 2'd1,
    STATE_ARB_WAIT   = 2'd2,
    STATE_ARB_RESP   = 2'd3
  } arbState_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Memory is word addressed on the bus: drop the byte offset.
  function automatic logic [31:0] wordAlign(input logic [31:0] iwAddr);
    return iwAddr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/arb_pick_rv.sv
// Combinational winner selection for two requesters. A tie goes to the
// master that was not granted last; a caller wanting fixed priority for
// M0 simply ties iwLastGnt to ARB_M1.
module arb_pick_rv
  import mem_arbiter_rv_pkg::*;
(
  input  logic iwReq0,
  input  logic iwReq1,
  input  logic iwLastGnt,
  output logic owWinner,
  output logic owValid
);

  // Pick the winner among the active requests
  always_comb begin
    owValid = iwReq0 | iwReq1;
    if (iwReq0 && iwReq1) begin
      owWinner = (iwLastGnt == ARB_M0) ? ARB_M1 : ARB_M0;
    end else if (iwReq1) begin
      owWinner = ARB_M1;
    end else begin
      owWinner = ARB_M0;
    end
  end

endmodule

// File: rtl/mem_arbiter_rv.sv
// Two-master (core / debug-DMA) single-port memory arbiter.
// One transaction at a time: IDLE samples requests, ACCESS issues the
// memory strobe and grant, WAIT covers the read latency, RESP pulses the
// completion to the owning master.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// without it M0 always wins ties and no last-grant pointer is kept.
module mem_arbiter_rv
  import mem_arbiter_rv_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwM0Req,
  input  logic [31:0] iwM0Addr,
  input  logic [31:0] iwM0Wdata,
  input  logic [3:0]  iwM0Wstrb,
  output logic        orM0Gnt,
  output logic        orM0Rvalid,
  output logic [31:0] orM0Rdata,
  input  logic        iwM1Req,
  input  logic [31:0] iwM1Addr,
  input  logic [31:0] iwM1Wdata,
  input  logic [3:0]  iwM1Wstrb,
  output logic        orM1Gnt,
  output logic        orM1Rvalid,
  output logic [31:0] orM1Rdata,
  output logic        orMemEn,
  output logic [31:0] orMemAddr,
  output logic [31:0] orMemWdata,
  output logic [3:0]  orMemWstrb,
  input  logic [31:0] iwMemRdata,
  output logic        orBusy
);

  // WAIT lasts READ_LATENCY cycles; the counter runs from this value to 0.
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  arbState_t   rState;
  arbState_t   wNextState;
  logic [1:0]  rLatCnt;
  logic        rOwner;
  logic        rIsRead;
  logic        wPickWinner;
  logic        wPickValid;
  logic        wLastGnt;
  logic [31:0] wSelAddr;
  logic [31:0] wSelWdata;
  logic [3:0]  wSelWstrb;
  logic        wLoad;
  logic        wCapture;
  logic        wBusyNext;
  logic        wGnt0Next;
  logic        wGnt1Next;
  logic        wRvalid0Next;
  logic        wRvalid1Next;

`ifdef ARB_ROUND_ROBIN_EN
  logic rLastGnt;

  // Remember who was granted last; reset value lets M0 win the first tie
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rLastGnt <= ARB_M1;
    end else if (wLoad) begin
      rLastGnt <= wPickWinner;
    end
  end

  assign wLastGnt = rLastGnt;
`else
  assign wLastGnt = ARB_M1;
`endif

  arb_pick_rv uPick (
    .iwReq0    (iwM0Req),
    .iwReq1    (iwM1Req),
    .iwLastGnt (wLastGnt),
    .owWinner  (wPickWinner),
    .owValid   (wPickValid)
  );

  // Route the winning master's request payload toward the memory latch
  always_comb begin
    if (wPickWinner == ARB_M1) begin
      wSelAddr  = iwM1Addr;
      wSelWdata = iwM1Wdata;
      wSelWstrb = iwM1Wstrb;
    end else begin
      wSelAddr  = iwM0Addr;
      wSelWdata = iwM0Wdata;
      wSelWstrb = iwM0Wstrb;
    end
  end

  // Next-state logic of the transaction FSM
  always_comb begin
    wNextState = rState;
    case (rState)
      STATE_ARB_IDLE: begin
        if (wPickValid) begin
          wNextState = STATE_ARB_ACCESS;
        end else begin
          wNextState = STATE_ARB_IDLE;
        end
      end
      STATE_ARB_ACCESS: begin
        if (rIsRead) begin
          wNextState = STATE_ARB_WAIT;
        end else begin
          wNextState = STATE_ARB_RESP;
        end
      end
      STATE_ARB_WAIT: begin
        if (rLatCnt == 2'd0) begin
          wNextState = STATE_ARB_RESP;
        end else begin
          wNextState = STATE_ARB_WAIT;
        end
      end
      STATE_ARB_RESP: begin
        wNextState = STATE_ARB_IDLE;
      end
      default: begin
        wNextState = STATE_ARB_IDLE;
      end
    endcase
  end

  // Output decode: next-cycle values of the registered strobes
  always_comb begin
    wLoad        = (rState == STATE_ARB_IDLE) && wPickValid;
    wCapture     = (rState == STATE_ARB_WAIT) && (rLatCnt == 2'd0);
    wBusyNext    = (wNextState != STATE_ARB_IDLE);
    wGnt0Next    = wLoad && (wPickWinner == ARB_M0);
    wGnt1Next    = wLoad && (wPickWinner == ARB_M1);
    wRvalid0Next = (wNextState == STATE_ARB_RESP) && (rOwner == ARB_M0);
    wRvalid1Next = (wNextState == STATE_ARB_RESP) && (rOwner == ARB_M1);
  end

  // State register and registered control strobes
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rState     <= STATE_ARB_IDLE;
      orBusy     <= 1'b0;
      orMemEn    <= 1'b0;
      orM0Gnt    <= 1'b0;
      orM1Gnt    <= 1'b0;
      orM0Rvalid <= 1'b0;
      orM1Rvalid <= 1'b0;
    end else begin
      rState     <= wNextState;
      orBusy     <= wBusyNext;
      orMemEn    <= wLoad;
      orM0Gnt    <= wGnt0Next;
      orM1Gnt    <= wGnt1Next;
      orM0Rvalid <= wRvalid0Next;
      orM1Rvalid <= wRvalid1Next;
    end
  end

  // Latch the winner's request on grant; memory bus holds it afterwards
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      orMemAddr  <= 32'h0000_0000;
      orMemWdata <= 32'h0000_0000;
      orMemWstrb <= 4'h0;
      rOwner     <= ARB_M0;
      rIsRead    <= 1'b0;
    end else if (wLoad) begin
      orMemAddr  <= wordAlign(wSelAddr);
      orMemWdata <= wSelWdata;
      orMemWstrb <= wSelWstrb;
      rOwner     <= wPickWinner;
      rIsRead    <= (wSelWstrb == 4'h0);
    end
  end

  // Read latency counter: loaded leaving ACCESS, counts down through WAIT
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rLatCnt <= 2'd0;
    end else if (rState == STATE_ARB_ACCESS) begin
      rLatCnt <= LAT_LOAD;
    end else if ((rState == STATE_ARB_WAIT) && (rLatCnt != 2'd0)) begin
      rLatCnt <= rLatCnt - 2'd1;
    end
  end

  // Capture returning read data for the owning master on the last WAIT cycle
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      orM0Rdata <= 32'h0000_0000;
      orM1Rdata <= 32'h0000_0000;
    end else if (wCapture) begin
      if (rOwner == ARB_M1) begin
        orM1Rdata <= iwMemRdata;
      end else begin
        orM0Rdata <= iwMemRdata;
      end
    end
  end

endmodule
